latch_wr_ctrl: RTL and testbench
================================

LATCH_WR_CTRL -- requirements
Module: latch_wr_ctrl

Interface
REQ-001 SHALL have parameter NumWords, default 8, number of latch rows (2..256).
REQ-002 SHALL have parameter DataWidth, default 32, bits per row.
REQ-003 SHALL have parameter NumPorts, default 2, number of write requesters (1..8).
REQ-004 SHALL define derived AddrWidth = max(1, clog2(NumWords)).
REQ-005 SHALL have clk_i, input, 1: single clock; all state updates on the rising edge.
REQ-006 SHALL have rst_i, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have req_i, input, NumPorts: per-port write request.
REQ-008 SHALL have addr_i, input, NumPorts x AddrWidth: per-port row address.
REQ-009 SHALL have wdata_i, input, NumPorts x DataWidth: per-port write data.
REQ-010 SHALL have gnt_o, output, NumPorts: one-hot grant pulse.
REQ-011 SHALL have latch_en_o, output, NumWords: one-hot row enables to the latch array.
REQ-012 SHALL have latch_wdata_o, output, DataWidth: data presented to all rows.
REQ-013 SHALL have busy_o, output, 1: a write sequence is in progress.
REQ-014 SHALL have err_o, output, 1: one-cycle pulse for an out-of-range address.

Function
REQ-015 SHALL implement FSM states IDLE, SETUP, ENABLE, HOLD.
REQ-016 In IDLE with any req_i set, SHALL assert exactly one gnt_o bit combinationally in that cycle and go to SETUP at the next edge.
REQ-017 At a grant, SHALL capture the granted addr_i and wdata_i into internal registers; requesters may drop or change req_i, addr_i and wdata_i after the granting edge.
REQ-018 SHALL arbitrate round-robin: search starts at the port after the last granted port, wrapping at NumPorts-1 to 0; after reset, search starts at port 0.
REQ-019 SHALL drive gnt_o to zero in every state except IDLE.
REQ-020 SETUP SHALL last 1 cycle with latch_wdata_o equal to the captured data and latch_en_o all zero, then go to ENABLE.
REQ-021 ENABLE SHALL last 1 cycle with latch_en_o[addr] = 1 and all other bits 0, then go to HOLD.
REQ-022 HOLD SHALL last 1 cycle with latch_en_o all zero and latch_wdata_o unchanged, then go to IDLE.
REQ-023 A write SHALL occupy 4 cycles from the grant cycle; maximum throughput is 1 write per 4 cycles.
REQ-024 latch_en_o SHALL be driven directly from flip-flops, with no combinational logic after the register, so it is glitch-free.
REQ-025 latch_wdata_o SHALL be registered; it SHALL change only on the edge entering SETUP and hold its value through ENABLE, HOLD and the following IDLE until the next grant.
REQ-026 busy_o SHALL be 1 in SETUP, ENABLE and HOLD, and 0 in IDLE.
REQ-027 If the captured address is >= NumWords, the FSM SHALL still pass through SETUP, ENABLE and HOLD, keep latch_en_o all zero, and pulse err_o for 1 cycle during ENABLE.
REQ-028 Requests arriving while busy_o = 1 SHALL NOT be granted and SHALL NOT be lost, provided they are held until granted.
REQ-029 With a single requester and NumPorts = 1, grants SHALL occur every 4 cycles while req_i is held.

Reset
REQ-030 On a clock edge with rst_i = 1, the FSM SHALL go to IDLE and the round-robin pointer SHALL select port 0 as the first candidate.
REQ-031 During reset, latch_en_o, latch_wdata_o, busy_o and err_o SHALL be 0, and gnt_o SHALL be 0 while rst_i = 1.
REQ-032 Reset during ENABLE SHALL force latch_en_o to 0 at that edge; the partial write is abandoned and no retry is made.
REQ-033 The first grant after reset deasserts SHALL be possible in the first cycle with rst_i = 0.

Verification
REQ-034 Single write: port0 req, addr 3, data 0xA5A5A5A5 -> gnt_o=01 in cycle 0; latch_wdata_o=0xA5A5A5A5 from cycle 1; latch_en_o=0x08 only in cycle 2; busy_o high in cycles 1-3.
REQ-035 Contention: ports 0 and 1 request continuously from reset -> grants alternate 01, 10, 01, ... at 4-cycle spacing.
REQ-036 Out-of-range (NumWords=6): addr 7 -> latch_en_o stays 0, err_o high for 1 cycle at ENABLE, busy_o for 3 cycles.
REQ-037 Reset mid-write: rst_i=1 sampled during ENABLE -> latch_en_o=0 and busy_o=0 after that edge; next request is granted to port 0.
REQ-038 Request during busy: port1 requests at SETUP of a port0 write -> port1 granted exactly in the next IDLE cycle.
REQ-039 Stability check: over random traffic, assert that latch_en_o is at most one-hot and never asserted in the same cycle that latch_wdata_o changes.

Source files
------------

// File: rtl/latch_wr_ctrl.sv
// -----------------------------------------------------------------------------
// latch_wr_ctrl
// Write sequencer for a latch-based register array. Several requesters compete
// for the array through a round-robin arbiter. The granted address and data are
// captured, and one write then runs through SETUP -> ENABLE -> HOLD. The data
// is stable for a whole cycle before and after the single enable cycle, so the
// latches capture clean data.
//
// Ports
//   clk_i          clock; all state changes on the rising edge
//   rst_i          synchronous, active-high reset
//   req_i          per-port write request
//   addr_i         per-port row address, packed port-major
//   wdata_i        per-port write data, packed port-major
//   gnt_o          one-hot grant, combinational, only in IDLE
//   latch_en_o     one-hot row enable, straight from flip-flops
//   latch_wdata_o  registered data presented to every row
//   busy_o         a write sequence is in progress
//   err_o          one-cycle pulse in ENABLE when the row address is out of range
// -----------------------------------------------------------------------------
module latch_wr_ctrl #(
    parameter int NumWords  = 8,
    parameter int DataWidth = 32,
    parameter int NumPorts  = 2,
    localparam int AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NumPorts-1:0]             req_i,
    input  logic [NumPorts*AddrWidth-1:0]   addr_i,
    input  logic [NumPorts*DataWidth-1:0]   wdata_i,
    output logic [NumPorts-1:0]             gnt_o,
    output logic [NumWords-1:0]             latch_en_o,
    output logic [DataWidth-1:0]            latch_wdata_o,
    output logic                            busy_o,
    output logic                            err_o
);

    localparam int PortW = (NumPorts > 1) ? $clog2(NumPorts) : 1;
    // One extra bit so that NumWords itself can be represented for the range check.
    localparam logic [AddrWidth:0] RowLimit = (AddrWidth+1)'(NumWords);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ENABLE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t                 state_r;
    logic [PortW-1:0]       ptr_r;
    logic [AddrWidth-1:0]   addr_r;
    logic [DataWidth-1:0]   data_r;
    logic [NumWords-1:0]    en_r;
    logic                   busy_r;
    logic                   err_r;

    logic [PortW-1:0]       gnt_idx_s;
    logic                   found_s;
    logic                   grant_s;
    logic [AddrWidth-1:0]   addr_sel_s;
    logic [DataWidth-1:0]   data_sel_s;
    logic [NumWords-1:0]    row_dec_s;
    logic                   row_ok_s;

    // Port index base+off, wrapped modulo NumPorts (off never exceeds NumPorts-1).
    function automatic logic [PortW-1:0] wrap_port(input int base, input int off);
        int sum;
        sum = base + off;
        if (sum >= NumPorts) begin
            sum = sum - NumPorts;
        end else begin
            sum = sum;
        end
        return PortW'(sum);
    endfunction

    // Round-robin search: the first requesting port at or after ptr_r wins.
    always_comb begin
        found_s   = 1'b0;
        gnt_idx_s = {PortW{1'b0}};
        for (int i = 0; i < NumPorts; i++) begin
            gnt_idx_s = (req_i[wrap_port(int'(ptr_r), i)] && !found_s)
                        ? wrap_port(int'(ptr_r), i) : gnt_idx_s;
            found_s   = found_s | req_i[wrap_port(int'(ptr_r), i)];
        end
    end

    // Grant is only issued in IDLE and is suppressed while reset is asserted.
    always_comb begin
        grant_s = found_s && (state_r == IDLE) && !rst_i;
        gnt_o   = {NumPorts{1'b0}};
        gnt_o[gnt_idx_s] = grant_s;
    end

    // AND-OR mux selecting the address and data of the winning port.
    always_comb begin
        addr_sel_s = {AddrWidth{1'b0}};
        data_sel_s = {DataWidth{1'b0}};
        for (int p = 0; p < NumPorts; p++) begin
            addr_sel_s = addr_sel_s | ({AddrWidth{gnt_idx_s == PortW'(p)}}
                                       & addr_i[p*AddrWidth +: AddrWidth]);
            data_sel_s = data_sel_s | ({DataWidth{gnt_idx_s == PortW'(p)}}
                                       & wdata_i[p*DataWidth +: DataWidth]);
        end
    end

    // Row decode of the captured address. Out-of-range rows decode to all zero.
    always_comb begin
        row_ok_s  = ({1'b0, addr_r} < RowLimit);
        row_dec_s = {NumWords{1'b0}};
        for (int w = 0; w < NumWords; w++) begin
            row_dec_s[w] = row_ok_s && (addr_r == AddrWidth'(w));
        end
    end

    // Write-sequence FSM. Every output is a flop that this block updates.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= IDLE;
            ptr_r   <= {PortW{1'b0}};
            addr_r  <= {AddrWidth{1'b0}};
            data_r  <= {DataWidth{1'b0}};
            en_r    <= {NumWords{1'b0}};
            busy_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_s) begin
                        state_r <= SETUP;
                        addr_r  <= addr_sel_s;
                        data_r  <= data_sel_s;
                        ptr_r   <= wrap_port(int'(gnt_idx_s), 1);
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                    en_r  <= {NumWords{1'b0}};
                    err_r <= 1'b0;
                end
                SETUP: begin
                    state_r <= ENABLE;
                    en_r    <= row_dec_s;
                    err_r   <= !row_ok_s;
                end
                ENABLE: begin
                    state_r <= HOLD;
                    en_r    <= {NumWords{1'b0}};
                    err_r   <= 1'b0;
                end
                HOLD: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    en_r    <= {NumWords{1'b0}};
                    busy_r  <= 1'b0;
                    err_r   <= 1'b0;
                end
            endcase
        end
    end

    assign latch_en_o    = en_r;
    assign latch_wdata_o = data_r;
    assign busy_o        = busy_r;
    assign err_o         = err_r;

endmodule

// File: tb/tb_latch_wr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_latch_wr_ctrl
// Directed bench. The driver pushes the expected grants, row enables and error
// pulses, each tagged with its cycle number, into queues. A monitor pops and
// compares them whenever the DUT shows a grant, an enable or an error. The
// driver checks busy and data directly along each write sequence.
// -----------------------------------------------------------------------------
module tb_latch_wr_ctrl;

    localparam int NW = 6;
    localparam int DW = 32;
    localparam int NP = 2;
    localparam int AW = 3;

    logic              clk;
    logic              rst;
    logic [NP-1:0]     req;
    logic [NP*AW-1:0]  addr;
    logic [NP*DW-1:0]  wdata;
    logic [NP-1:0]     gnt;
    logic [NW-1:0]     en;
    logic [DW-1:0]     lwdata;
    logic              busy;
    logic              err;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    int           gnt_cyc_q[$];
    logic [NP-1:0] gnt_val_q[$];
    int           en_cyc_q[$];
    logic [NW-1:0] en_val_q[$];
    logic [DW-1:0] en_dat_q[$];
    int           err_cyc_q[$];

    latch_wr_ctrl #(.NumWords(NW), .DataWidth(DW), .NumPorts(NP)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .addr_i(addr), .wdata_i(wdata),
        .gnt_o(gnt), .latch_en_o(en), .latch_wdata_o(lwdata),
        .busy_o(busy), .err_o(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle number: incremented on every rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
        addr[p*AW +: AW]  = a;
        wdata[p*DW +: DW] = d;
    endtask

    task automatic exp_write(input int c, input logic [NP-1:0] g,
                             input logic [NW-1:0] e, input logic [DW-1:0] d);
        gnt_cyc_q.push_back(c);
        gnt_val_q.push_back(g);
        if (e != 6'b000000) begin
            en_cyc_q.push_back(c + 2);
            en_val_q.push_back(e);
            en_dat_q.push_back(d);
        end else begin
            err_cyc_q.push_back(c + 2);
        end
    endtask

    // Monitor: compares every grant, enable and error pulse against the queues.
    initial begin : monitor
        logic [DW-1:0] prev_wdata;
        prev_wdata = 32'h0;
        forever begin
            @(negedge clk);
            if (gnt != 2'b00) begin
                if (gnt_cyc_q.size() == 0) begin
                    chk("gnt_unexpected", 64'(gnt), 64'h0);
                end else begin
                    chk("gnt_cycle", 64'(cyc), 64'(gnt_cyc_q.pop_front()));
                    chk("gnt_value", 64'(gnt), 64'(gnt_val_q.pop_front()));
                end
            end
            if (en != 6'b000000) begin
                chk("en_onehot", 64'($onehot(en)), 64'h1);
                chk("en_wdata_stable", 64'(lwdata), 64'(prev_wdata));
                if (en_cyc_q.size() == 0) begin
                    chk("en_unexpected", 64'(en), 64'h0);
                end else begin
                    chk("en_cycle", 64'(cyc), 64'(en_cyc_q.pop_front()));
                    chk("en_value", 64'(en), 64'(en_val_q.pop_front()));
                    chk("en_wdata", 64'(lwdata), 64'(en_dat_q.pop_front()));
                end
            end
            if (err) begin
                if (err_cyc_q.size() == 0) begin
                    chk("err_unexpected", 64'(err), 64'h0);
                end else begin
                    chk("err_cycle", 64'(cyc), 64'(err_cyc_q.pop_front()));
                end
            end
            prev_wdata = lwdata;
        end
    end

    // Driver with direct busy / data checks along each sequence.
    initial begin : driver
        int c;
        rst = 1'b1; req = 2'b00; addr = '0; wdata = '0;
        next_cycle();
        next_cycle();
        // Reset state, with requests present.
        req = 2'b11;
        #1;
        chk("rst_gnt", 64'(gnt), 64'h0);
        chk("rst_en", 64'(en), 64'h0);
        chk("rst_wdata", 64'(lwdata), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_err", 64'(err), 64'h0);
        next_cycle();
        rst = 1'b0; req = 2'b00;

        // Single write: port0, addr 3, 0xA5A5A5A5.
        next_cycle();
        c = cyc;
        set_port(0, 3'd3, 32'hA5A5A5A5); req = 2'b01;
        exp_write(c, 2'b01, 6'b001000, 32'hA5A5A5A5);
        chk("w1_busy_c0", 64'(busy), 64'h0);
        next_cycle(); req = 2'b00;
        chk("w1_busy_c1", 64'(busy), 64'h1);
        chk("w1_wdata_c1", 64'(lwdata), 64'hA5A5A5A5);
        chk("w1_en_c1", 64'(en), 64'h0);
        next_cycle();
        chk("w1_busy_c2", 64'(busy), 64'h1);
        next_cycle();
        chk("w1_busy_c3", 64'(busy), 64'h1);
        chk("w1_en_c3", 64'(en), 64'h0);
        next_cycle();
        chk("w1_busy_c4", 64'(busy), 64'h0);
        chk("w1_wdata_c4", 64'(lwdata), 64'hA5A5A5A5);

        // Out-of-range: port1, addr 7.
        next_cycle();
        c = cyc;
        set_port(1, 3'd7, 32'h12345678); req = 2'b10;
        exp_write(c, 2'b10, 6'b000000, 32'h0);
        next_cycle(); req = 2'b00;
        chk("oor_busy_c1", 64'(busy), 64'h1);
        chk("oor_wdata_c1", 64'(lwdata), 64'h12345678);
        next_cycle();
        chk("oor_busy_c2", 64'(busy), 64'h1);
        chk("oor_en_c2", 64'(en), 64'h0);
        chk("oor_err_c2", 64'(err), 64'h1);
        next_cycle();
        chk("oor_busy_c3", 64'(busy), 64'h1);
        chk("oor_err_c3", 64'(err), 64'h0);
        next_cycle();
        chk("oor_busy_c4", 64'(busy), 64'h0);

        // Request during busy: port1 asks in SETUP of a port0 write.
        next_cycle();
        c = cyc;
        set_port(0, 3'd1, 32'h11111111); req = 2'b01;
        exp_write(c, 2'b01, 6'b000010, 32'h11111111);
        exp_write(c + 4, 2'b10, 6'b100000, 32'h55555555);
        next_cycle();
        set_port(1, 3'd5, 32'h55555555); req = 2'b10;
        for (int k = 1; k <= 3; k++) begin
            #1;
            chk("busy_no_gnt", 64'(gnt), 64'h0);
            next_cycle();
        end
        chk("busy_c4_idle", 64'(busy), 64'h0);
        next_cycle(); req = 2'b00;
        for (int k = 0; k < 4; k++) next_cycle();

        // Reset during ENABLE, then contention from the first cycle out of reset.
        next_cycle();
        c = cyc;
        set_port(0, 3'd0, 32'hDEADBEEF); req = 2'b01;
        exp_write(c, 2'b01, 6'b000001, 32'hDEADBEEF);
        next_cycle(); req = 2'b00;
        next_cycle(); rst = 1'b1;
        next_cycle();
        chk("rst_mid_en", 64'(en), 64'h0);
        chk("rst_mid_busy", 64'(busy), 64'h0);
        chk("rst_mid_wdata", 64'(lwdata), 64'h0);
        rst = 1'b0;
        c = cyc;
        set_port(0, 3'd2, 32'hAAAA0000);
        set_port(1, 3'd4, 32'hBBBB0000);
        req = 2'b11;
        exp_write(c,      2'b01, 6'b000100, 32'hAAAA0000);
        exp_write(c + 4,  2'b10, 6'b010000, 32'hBBBB0000);
        exp_write(c + 8,  2'b01, 6'b000100, 32'hAAAA0000);
        exp_write(c + 12, 2'b10, 6'b010000, 32'hBBBB0000);
        for (int k = 0; k < 13; k++) next_cycle();
        req = 2'b00;
        for (int k = 0; k < 8; k++) next_cycle();

        chk("gnt_q_drained", 64'(gnt_cyc_q.size()), 64'h0);
        chk("en_q_drained", 64'(en_cyc_q.size()), 64'h0);
        chk("err_q_drained", 64'(err_cyc_q.size()), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
